aes128_byte_serial_enc: RTL and testbench

- Low-area AES-128 encryption core (FIPS-197) with a byte-serial interface.
- An `en` pulse opens a session: 16 key bytes are loaded, then 16 plaintext bytes, one byte per clock.
- The core then runs 10 rounds iteratively and streams the 16 ciphertext bytes out with a valid flag.
- Sits behind a byte-wide datapath (UART/bus bridge) where area matters more than throughput.

---
 rtl/aes128_byte_serial_enc_pkg.sv | 44 ++++
 rtl/aes128_byte_serial_enc_if.sv | 15 +
 rtl/aes128_byte_serial_enc_sbox.sv | 30 +++
 rtl/aes128_byte_serial_enc.sv | 139 +++++++++++++
 tb/tb_aes128_byte_serial_enc.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes128_byte_serial_enc_pkg.sv
// Shared definitions for the byte-serial AES-128 encryption core.
//   aes_state_e   : top-level FSM states
//   NUM_ROUNDS    : AES-128 round count
//   BLOCK_BYTES   : bytes per key / block
//   ROUND_CYCLES  : clocks per iterative round (16 S-box slots + 1 mix/key slot)
//   RCON          : key schedule round constants, RCON[0] is round 1
//   xtime, mix_column : GF(2^8) helpers for MixColumns
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_PT,
    ROUND,
    OUTPUT
  } aes_state_e;

  localparam int NUM_ROUNDS   = 10;
  localparam int BLOCK_BYTES  = 16;
  localparam int ROUND_CYCLES = 17;

  localparam logic [NUM_ROUNDS-1:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; col[31:24] is row 0.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes128_byte_serial_enc_if.sv
// Byte-serial bus of the AES-128 core.
//   en           : session start pulse (host -> core)
//   input_data   : key / plaintext byte (host -> core)
//   output_data  : ciphertext byte, zero when not valid (core -> host)
//   output_ready : ciphertext byte valid (core -> host)
// master = host side, slave = core side.
interface aes128_byte_serial_enc_if;
  logic       en;
  logic [7:0] input_data;
  logic [7:0] output_data;
  logic       output_ready;

  modport master (output en, output input_data, input output_data, input output_ready);
  modport slave  (input en, input input_data, output output_data, output output_ready);
endinterface

// File: rtl/aes128_byte_serial_enc_sbox.sv
// Forward AES S-box, purely combinational lookup.
//   i_in  : input byte
//   o_out : substituted byte
module aes_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign o_out = SBOX[i_in];

endmodule

// File: rtl/aes128_byte_serial_enc.sv
// Low-area AES-128 encryptor with a byte-serial interface.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of aes128_byte_serial_enc_if (en, input_data in;
//         output_data, output_ready out)
// Session: en in IDLE, 16 key bytes, 16 plaintext bytes, 10 rounds of
// 17 cycles, then 16 registered ciphertext bytes.
module aes128_byte_serial_enc
  import aes_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  aes128_byte_serial_enc_if.slave  bus
);

  // Byte i of a block lives at index 15-i (== ~i on 4 bits), so the packed
  // array read as a 128-bit vector is the FIPS-197 big-endian block and
  // column c is bits [127-32c -: 32].
  aes_state_e             r_fsm, w_fsm_next;
  logic [3:0]             r_cnt;
  logic [4:0]             r_cyc;
  logic [3:0]             r_round;
  logic [15:0][7:0]       r_state, r_next, r_key;
  logic [3:0][7:0]        r_temp;
  logic [7:0]             r_out_data;
  logic                   r_out_ready;

  logic [7:0]             w_sbox_out, w_ksbox_out;
  logic [1:0]             w_dst_col, w_kidx;
  logic [3:0]             w_dst;
  logic                   w_round_end, w_last, w_cnt_last;
  logic [31:0]            w_kw0, w_kw1, w_kw2, w_kw3;
  logic [15:0][7:0]       w_new_key, w_new_state;
  logic [127:0]           w_next_flat, w_mixed;

  assign w_round_end = (r_cyc == 5'(ROUND_CYCLES - 1));
  assign w_last      = (r_round == 4'(NUM_ROUNDS - 1));
  assign w_cnt_last  = (r_cnt == 4'(BLOCK_BYTES - 1));

  // ShiftRows folded into the write address: byte at (row r, col c)
  // moves to column c-r of the same row.
  assign w_dst_col = r_cyc[3:2] - r_cyc[1:0];
  assign w_dst     = {w_dst_col, r_cyc[1:0]};

  // RotWord: temp byte j comes from w[3] byte (j+1)%4.
  assign w_kidx = r_cyc[1:0] + 2'd1;

  aes_sbox u_data_sbox (.i_in(r_state[~r_cyc[3:0]]), .o_out(w_sbox_out));
  aes_sbox u_key_sbox  (.i_in(r_key[{2'b00, ~w_kidx}]), .o_out(w_ksbox_out));

  // Next round key from the finished SubWord/RotWord/Rcon temp word.
  assign w_kw0     = r_key[15:12] ^ r_temp;
  assign w_kw1     = r_key[11:8]  ^ w_kw0;
  assign w_kw2     = r_key[7:4]   ^ w_kw1;
  assign w_kw3     = r_key[3:0]   ^ w_kw2;
  assign w_new_key = {w_kw0, w_kw1, w_kw2, w_kw3};

  assign w_next_flat = r_next;
  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign w_mixed[127-32*c -: 32] = w_last ? w_next_flat[127-32*c -: 32]
                                            : mix_column(w_next_flat[127-32*c -: 32]);
  end
  assign w_new_state = w_mixed ^ w_new_key;

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      IDLE:     if (bus.en)                w_fsm_next = LOAD_KEY;
      LOAD_KEY: if (w_cnt_last)            w_fsm_next = LOAD_PT;
      LOAD_PT:  if (w_cnt_last)            w_fsm_next = ROUND;
      ROUND:    if (w_round_end && w_last) w_fsm_next = OUTPUT;
      OUTPUT:   if (w_cnt_last)            w_fsm_next = IDLE;
      default:                             w_fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_cyc       <= '0;
      r_round     <= '0;
      r_state     <= '0;
      r_next      <= '0;
      r_key       <= '0;
      r_temp      <= '0;
      r_out_data  <= '0;
      r_out_ready <= 1'b0;
    end else begin
      r_out_data  <= '0;
      r_out_ready <= 1'b0;
      case (r_fsm)
        IDLE: begin
          r_cnt   <= '0;
          r_cyc   <= '0;
          r_round <= '0;
          r_key   <= '0;
          r_state <= '0;
        end
        LOAD_KEY: begin
          r_key[~r_cnt] <= bus.input_data;
          r_cnt         <= r_cnt + 4'd1;
        end
        LOAD_PT: begin
          // initial AddRoundKey on capture
          r_state[~r_cnt] <= bus.input_data ^ r_key[~r_cnt];
          r_cnt           <= r_cnt + 4'd1;
        end
        ROUND: begin
          if (w_round_end) begin
            r_state <= w_new_state;
            r_key   <= w_new_key;
            r_cyc   <= '0;
            r_round <= r_round + 4'd1;
          end else begin
            r_next[~w_dst] <= w_sbox_out;
            if (r_cyc < 5'd4)
              r_temp[~r_cyc[1:0]] <= w_ksbox_out ^ ((r_cyc == 5'd0) ? RCON[r_round] : 8'h00);
            r_cyc <= r_cyc + 5'd1;
          end
        end
        OUTPUT: begin
          r_out_data  <= r_state[~r_cnt];
          r_out_ready <= 1'b1;
          r_cnt       <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.output_data  = r_out_data;
  assign bus.output_ready = r_out_ready;

endmodule

// File: tb/tb_aes128_byte_serial_enc.sv
// Self-checking bench for aes128_byte_serial_enc: FIPS-197 vectors, latency,
// busy-stream, mid-round reset, back-to-back and random sessions against a
// behavioural AES model (S-box derived from GF(2^8) inversion).
module tb_aes128_byte_serial_enc;

  logic clk = 1'b0;
  logic rst;
  aes128_byte_serial_enc_if bus();

  aes128_byte_serial_enc dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [256];

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] SK  = 128'h5c3532af37ddcb96a8936788e85a7109;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) + affine map.
  task automatic build_sbox();
    logic [7:0] inv, xb;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, xb);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, t0, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ w[i];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        t0 = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[t0];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // en cycle (data on that edge is junk), then 16 key and 16 plaintext bytes.
  task automatic load_session(input logic [127:0] key, input logic [127:0] pt);
    bus.en = 1'b1;
    bus.input_data = 8'($urandom);
    tick();
    bus.en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.input_data = key[127-8*i -: 8];
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      bus.input_data = pt[127-8*i -: 8];
      tick();
    end
    bus.input_data = 8'h00;
  endtask

  // Called at the first sample after the last plaintext capture.
  task automatic expect_block(input logic [127:0] exp, input bit noise, input string tag);
    int n;
    logic [127:0] got;
    n = 0;
    got = '0;
    while (bus.output_ready !== 1'b1 && n < 400) begin
      if (noise) begin
        bus.en = (n < 100) ? 1'($urandom) : 1'b0;
        bus.input_data = 8'($urandom);
      end
      tick();
      n++;
    end
    bus.en = 1'b0;
    bus.input_data = 8'h00;
    checks++;
    assert (n === 171) else begin
      errors++;
      $error("FAIL %s latency: observed %0d expected 171", tag, n);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      assert (bus.output_ready === 1'b1) else begin
        errors++;
        $error("FAIL %s ready[%0d]: observed %b expected 1", tag, k, bus.output_ready);
      end
      got[127-8*k -: 8] = bus.output_data;
      tick();
    end
    checks++;
    assert ({bus.output_ready, bus.output_data} === 9'h000) else begin
      errors++;
      $error("FAIL %s post-burst: observed %b/%h expected 0/00", tag, bus.output_ready, bus.output_data);
    end
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s ciphertext: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Watch for any output activity over a window.
  task automatic expect_quiet(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.output_ready !== 1'b0 || bus.output_data !== 8'h00) seen++;
    end
    checks++;
    assert (seen === 0) else begin
      errors++;
      $error("FAIL %s: observed %0d active cycles expected 0", tag, seen);
    end
  endtask

  initial begin
    logic [127:0] rk, rp;
    build_sbox();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.input_data = 8'h00;
    tick();
    checks++;
    assert ({bus.output_ready, bus.output_data} === 9'h000) else begin
      errors++;
      $error("FAIL reset_out: observed %b/%h expected 0/00", bus.output_ready, bus.output_data);
    end
    rst = 1'b0;
    bus.input_data = 8'ha5;
    expect_quiet(100, "idle_quiet");
    bus.input_data = 8'h00;

    load_session(C1K, C1P);
    expect_block(C1C, 1'b0, "fips_c1");

    // en on the cycle right after the burst
    load_session(BK, BP);
    expect_block(BC, 1'b0, "b2b_appB");

    // 64-byte stream with en noise during rounds
    load_session(SK, SK);
    expect_block(aes_ref(SK, SK), 1'b1, "busy_stream");
    expect_quiet(250, "busy_single_burst");

    // reset in round 5 (round index 4, a few cycles in)
    load_session(C1K, C1P);
    for (int i = 0; i < 4 * 17 + 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_quiet(250, "midround_reset_quiet");
    load_session(BK, BP);
    expect_block(BC, 1'b0, "post_reset_appB");

    for (int s = 0; s < 3; s++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) tick();
      load_session(rk, rp);
      expect_block(aes_ref(rk, rp), 1'b0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
